// File: rtl/cla_mp_seq_adder.sv
// Multi-precision sequential adder: one 16-bit CLA, one limb per clock, LSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a_in, b_in, cin
// (and sub when CLA_MP_SUB_EN is defined); out_valid/out_ready with sum, cout, ovf.
// CLA_MP_SUB_EN: adds the sub port; sub=1 inverts B limbs and the initial carry.

module cla_16bit (
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  input  logic        cin,
  output logic [15:0] dout,
  output logic        cout,
  output logic        pg,
  output logic        gg
);
  logic [15:0] w_p, w_g;
  logic [3:0]  w_gp, w_gg;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_p = din1 ^ din2;
  assign w_g = din1 & din2;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Group carries resolved by lookahead from cin.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0])
                 | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1])
                 | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gc[3]);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_c[4*k] = w_gc[k];
      for (int j = 1; j < 4; j++)
        w_c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & w_c[4*k+j-1]);
    end
  end

  assign dout = w_p ^ w_c;
  assign cout = w_gc[4];
  assign pg   = &w_gp;
  assign gg   = w_gg[3] | (w_gp[3] & w_gg[2])
              | (w_gp[3] & w_gp[2] & w_gg[1])
              | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
endmodule

module cla_mp_seq_adder #(
  parameter int LIMBS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*LIMBS-1:0] a_in,
  input  logic [16*LIMBS-1:0] b_in,
  input  logic                cin,
`ifdef CLA_MP_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*LIMBS-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = 16 * LIMBS;
  localparam int IW = $clog2(LIMBS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_a, r_b, r_sum;
  logic [IW-1:0]  r_idx;
  logic           r_carry, r_cout, r_ovf;
  logic           w_accept, w_last;
  logic [15:0]    w_a_limb, w_b_limb, w_beff, w_dout;
  logic           w_cla_cout, w_cin0;

`ifdef CLA_MP_SUB_EN
  logic r_sub;
  assign w_beff = r_sub ? ~w_b_limb : w_b_limb;
  assign w_cin0 = sub ? ~cin : cin;
`else
  assign w_beff = w_b_limb;
  assign w_cin0 = cin;
`endif

  assign w_a_limb = r_a[16*r_idx +: 16];
  assign w_b_limb = r_b[16*r_idx +: 16];
  assign w_last   = (r_idx == IW'(LIMBS - 1));

  cla_16bit u_cla (
    .din1 (w_a_limb),
    .din2 (w_beff),
    .cin  (r_carry),
    .dout (w_dout),
    .cout (w_cla_cout),
    .pg   (),
    .gg   ()
  );

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_accept = in_valid;
          w_next   = in_valid ? S_RUN : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef CLA_MP_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a_in;
        r_b     <= b_in;
        r_idx   <= '0;
        r_carry <= w_cin0;
`ifdef CLA_MP_SUB_EN
        r_sub   <= sub;
`endif
      end else if (r_state == S_RUN) begin
        r_sum[16*r_idx +: 16] <= w_dout;
        r_carry <= w_cla_cout;
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_cla_cout;
          // Sign of A vs effective B vs result, all on the top limb.
          r_ovf  <= (r_a[W-1] == w_beff[15]) && (w_dout[15] != r_a[W-1]);
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_cla_mp_seq_adder.sv
// Scoreboard bench for cla_mp_seq_adder (LIMBS=4).
// Directed corner cases, stall/back-to-back, mid-op reset, random ops.

module tb_cla_mp_seq_adder;
  localparam int LIMBS = 4;
  localparam int W     = 16 * LIMBS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a_in, b_in;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] q[$];
  bit rnd_stall = 0;

  cla_mp_seq_adder #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
`ifdef CLA_MP_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, cout, sum} from an independent wide-add model.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b,
                                         input logic c, s);
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   r;
    logic         v;
    be = b;
    ci = c;
`ifdef CLA_MP_SUB_EN
    if (s) begin
      be = ~b;
      ci = ~c;
    end
`endif
    r = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
    v = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {v, r};
  endfunction

  // Call just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, b, input logic c, s);
    int t = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    cin = c;
    sub = s;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    q.push_back(model(a, b, c, s));
    #1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("result", {ovf, cout, sum}, q.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [W+1:0] e1;
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
`ifdef CLA_MP_SUB_EN
    send(64'h5, 64'h7, 1'b0, 1'b1);
`endif
    drain();

    // Stall in DONE with a pending request, then accept on release.
    out_ready = 1'b0;
    e1 = model(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
    in_valid = 1'b1;
    a_in = 64'h7FFF_FFFF_FFFF_FFFF;
    b_in = 64'h1;
    cin = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frozen_out", {out_valid, in_ready, ovf, cout, sum},
          {2'b10, e1});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    q.push_back(model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0));
    #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_latency_low", out_valid, 0);
    end
    @(negedge clk);
    chk("b2b_latency_high", out_valid, 1);
    @(posedge clk);
    #1;

    // Reset while RUN is at idx=2.
    send(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    @(posedge clk);
    #1;
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 1'b0);
    drain();

    rnd_stall = 1;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 10 == 0) a = '1;
      if (i % 15 == 0) b = {1'b0, {(W-1){1'b1}}};
      send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd_stall = 0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
